reg_mask_encoder32: RTL
=======================

Name: reg_mask_encoder32

Overview:
- Inverse of the 5-to-32 write-enable decoder: converts a 32-bit register mask back into a sequence of 5-bit register addresses.
- Captures a multi-hot mask, then emits one address per set bit through a valid/ready handshake.
- Used by the pipeline for multi-register writeback/flush sequencing and scoreboard drain.
- Sits between scoreboard/control logic (mask producer) and regfile address muxing (address consumer).

Parameters:
- LSB_FIRST, 1, 1 = emit lowest set bit first (addr 0 → 31); 0 = highest set bit first (31 → 0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous reset, active-low.
- load_valid  input  1  producer offers load_mask this cycle.
- load_ready  output  1  block can accept a new mask.
- load_mask  input  32  multi-hot register mask; bit i = register i.
- out_valid  output  1  out_addr holds a valid address.
- out_ready  input  1  consumer accepts out_addr this cycle.
- out_addr  output  5  encoded register address.
- out_last  output  1  out_addr is the final set bit of the current mask.
- busy  output  1  high while a mask is being drained (state DRAIN).

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - pending mask cleared; state IDLE.
  - out_valid=0, out_addr=0, out_last=0, busy=0, load_ready=1 from the next cycle.
  - Reset takes priority over every other event, including mid-drain: the drain is abandoned and no further addresses are emitted.
- States: IDLE, DRAIN.
- load_ready = (state==IDLE); purely combinational from state.
- load handshake occurs when load_valid && load_ready at a rising edge. load_mask is ignored whenever load_ready=0.
- IDLE, load handshake with load_mask != 0:
  - pending ← load_mask with the selected bit cleared.
  - out_addr ← selected index; out_valid ← 1; out_last ← (popcount==1).
  - state → DRAIN.
  - Latency: address visible the cycle after acceptance.
- IDLE, load handshake with load_mask == 0: accepted and dropped; no output; stays IDLE.
- Selected index = lowest set bit (LSB_FIRST=1) or highest set bit (LSB_FIRST=0).
- DRAIN, out_valid && !out_ready: out_addr, out_last, out_valid held stable (no change) until accepted.
- DRAIN, output handshake (out_valid && out_ready):
  - If out_last=0: out_addr ← next selected index from pending; that bit is cleared; out_last updated. Throughput is one address per cycle under continuous out_ready.
  - If out_last=1: out_valid ← 0, out_last ← 0, state → IDLE. load_ready=1 the following cycle; there is no same-cycle reload.
- out_addr is registered. It retains its last value while out_valid=0 (0 after reset).
- busy = (state==DRAIN).
- Each set bit is emitted exactly once; the order is strictly monotonic per LSB_FIRST.
- Full mask 32'hFFFFFFFF: 32 addresses, out_last on address 31 (LSB_FIRST=1) or address 0 (LSB_FIRST=0).

Optional Feature:
- Macro: REG_MASK_ENCODER32_COUNT_EN.
- When defined:
  - Adds output port out_remaining [5:0], registered.
  - Value = number of addresses still to be emitted, including the current out_addr.
  - Set to popcount(load_mask) on load; decrements on each output handshake; 0 in IDLE and after reset.
  - Range 0..32.
- When undefined: port absent; no popcount logic.

Test Plan:
- Reset then idle, reset_n=0 for 2 cycles → out_valid=0, out_addr=0, busy=0, load_ready=1.
- Load 32'h0000_8421, out_ready held 1, LSB_FIRST=1 → out_addr 0,5,10,15 on consecutive cycles; out_last only on 15; load_ready=1 the cycle after.
- Backpressure: load 32'h8000_0003, out_ready=0 for 3 cycles → out_addr=0 held stable with out_valid=1; then out_ready=1 → 1, 31; out_last on 31.
- LSB_FIRST=0, load 32'h8000_0003 → order 31,1,0.
- Load 0 → no out_valid; load_ready stays 1. Load 32'hFFFF_FFFF → 32 addresses 0..31 in 32 cycles; with COUNT_EN, out_remaining goes 32 → 1.
- Reset mid-drain: load 32'h0000_00FF, assert reset_n=0 after 3 addresses accepted → out_valid=0, busy=0 next cycle. New load 32'h10 → emits only 4.

Source files
------------

// File: rtl/reg_mask_encoder32.sv
`default_nettype none
// ============================================================================
// Module      : reg_mask_encoder32
// Description : Converts a captured 32-bit multi-hot register mask into a
//               stream of 5-bit register addresses, one per set bit, over a
//               valid/ready handshake. This is the inverse of a 5-to-32
//               write-enable decoder. It is used for multi-register writeback,
//               flush sequencing and scoreboard drain.
//
// Parameters  : LSB_FIRST  1 = lowest set bit first (0 -> 31)
//                          0 = highest set bit first (31 -> 0)
//
// Ports       : clk            system clock, rising edge
//               reset_n        synchronous reset, active-low
//               load_valid     producer offers load_mask
//               load_ready     block can accept a mask (state IDLE)
//               load_mask      multi-hot mask, bit i = register i
//               out_valid      out_addr holds a valid address
//               out_ready      consumer accepts out_addr
//               out_addr       encoded register address (registered)
//               out_last       out_addr is the final set bit of the mask
//               busy           high while a mask is being drained
//               out_remaining  addresses still to emit, including out_addr
//                              (present only with REG_MASK_ENCODER32_COUNT_EN)
//
// Options     : `define REG_MASK_ENCODER32_COUNT_EN adds out_remaining.
//
// Revision    : 1.0 - initial release
// ============================================================================
module reg_mask_encoder32 #(
    parameter int LSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_mask,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic        out_last,
    output logic        busy
`ifdef REG_MASK_ENCODER32_COUNT_EN
    ,
    output logic [5:0]  out_remaining
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pending;
    logic [31:0] w_pending_nxt;
    logic [4:0]  r_addr;
    logic [4:0]  w_addr_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        r_last;
    logic        w_last_nxt;

    // The selector works on the incoming mask while idle (first address) and
    // on the pending remainder while draining (every following address).
    logic [31:0] w_sel_src;
    logic [4:0]  w_sel_idx;
    logic [31:0] w_sel_cleared;

    assign w_sel_src     = (r_state == ST_IDLE) ? load_mask : r_pending;
    assign w_sel_cleared = w_sel_src & ~(32'd1 << w_sel_idx);

    // Priority encoder: the final assignment in the loop wins, so the scan
    // direction determines whether the lowest or the highest set bit is taken.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            always_comb begin
                w_sel_idx = 5'd0;
                for (int i = 31; i >= 0; i--) begin
                    if (w_sel_src[i]) begin
                        w_sel_idx = 5'(i);
                    end
                end
            end
        end else begin : g_msb_first
            always_comb begin
                w_sel_idx = 5'd0;
                for (int i = 0; i < 32; i++) begin
                    if (w_sel_src[i]) begin
                        w_sel_idx = 5'(i);
                    end
                end
            end
        end
    endgenerate

`ifdef REG_MASK_ENCODER32_COUNT_EN
    logic [5:0] r_remaining;
    logic [5:0] w_remaining_nxt;
    logic [5:0] w_popcount;

    always_comb begin
        w_popcount = 6'd0;
        for (int i = 0; i < 32; i++) begin
            w_popcount = w_popcount + 6'(load_mask[i]);
        end
    end

    assign out_remaining = r_remaining;
`else
    // Without the count option no population count is built.
`endif

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_addr_nxt    = r_addr;
        w_valid_nxt   = r_valid;
        w_last_nxt    = r_last;
`ifdef REG_MASK_ENCODER32_COUNT_EN
        w_remaining_nxt = r_remaining;
`endif
        case (r_state)
            ST_IDLE: begin
                // An all-zero mask is accepted and silently dropped.
                if (load_valid && (load_mask != 32'd0)) begin
                    w_pending_nxt = w_sel_cleared;
                    w_addr_nxt    = w_sel_idx;
                    w_valid_nxt   = 1'b1;
                    w_last_nxt    = (w_sel_cleared == 32'd0);
                    w_state_nxt   = ST_DRAIN;
`ifdef REG_MASK_ENCODER32_COUNT_EN
                    w_remaining_nxt = w_popcount;
`endif
                end
            end
            ST_DRAIN: begin
                if (r_valid && out_ready) begin
                    if (r_last) begin
                        // out_addr keeps its final value while idle.
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_pending_nxt = w_sel_cleared;
                        w_addr_nxt    = w_sel_idx;
                        w_last_nxt    = (w_sel_cleared == 32'd0);
                    end
`ifdef REG_MASK_ENCODER32_COUNT_EN
                    w_remaining_nxt = r_remaining - 6'd1;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_pending <= 32'd0;
            r_addr    <= 5'd0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
`ifdef REG_MASK_ENCODER32_COUNT_EN
            r_remaining <= 6'd0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_addr    <= w_addr_nxt;
            r_valid   <= w_valid_nxt;
            r_last    <= w_last_nxt;
`ifdef REG_MASK_ENCODER32_COUNT_EN
            r_remaining <= w_remaining_nxt;
`endif
        end
    end

    assign load_ready = (r_state == ST_IDLE);
    assign busy       = (r_state == ST_DRAIN);
    assign out_valid  = r_valid;
    assign out_addr   = r_addr;
    assign out_last   = r_last;

endmodule
`default_nettype wire
